sobel_rd_engine: RTL and testbench
==================================

SOBEL_RD_ENGINE -- requirements
Module: sobel_rd_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, response buffer depth in cache lines (power of 2).
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle pulse from HC_CONTROL_START write decode.
REQ-005 SHALL have port base_addr  in  42  buffer 0 base, cache-line address (t_ccip_clAddr).
REQ-006 SHALL have port size  in  32  buffer 0 length in cache lines.
REQ-007 SHALL have port c0TxAlmFull  in  1  CCI-P read request channel almost-full.
REQ-008 SHALL have port rd_req_valid  out  1  read request issue strobe.
REQ-009 SHALL have port rd_req_addr  out  42  cache-line address of request.
REQ-010 SHALL have port rd_req_mdata  out  16  {epoch, line_index[14:0]}.
REQ-011 SHALL have port rd_rsp_valid  in  1  read response valid (c0 rspValid, resp type RdLine).
REQ-012 SHALL have port rd_rsp_mdata  in  16  mdata returned with response.
REQ-013 SHALL have port rd_rsp_data  in  512  response cache line.
REQ-014 SHALL have ports out_valid out 1, out_ready in 1, out_data out 512, out_idx out 15  FWFT stream to sobel core.
REQ-015 SHALL have ports busy out 1 (state != S_RD_IDLE) and done out 1 (one-cycle completion pulse).

Function
REQ-016 SHALL implement states S_RD_IDLE, S_RD_FETCH, S_RD_FINISH.
REQ-017 SHALL, in S_RD_IDLE on start=1, latch base_addr and size, clear issued/outstanding counters, toggle epoch, enter S_RD_FETCH (or S_RD_FINISH if size==0) next cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL assert rd_req_valid (registered) in a cycle only when state==S_RD_FETCH, issued<size, c0TxAlmFull==0, and outstanding+fifo_count < FIFO_DEPTH.
REQ-020 SHALL drive rd_req_addr = base + issued (42-bit, wraps modulo 2^42) and rd_req_mdata = {epoch, issued[14:0]}; issued increments per request.
REQ-021 SHALL produce first request in the cycle after start if not stalled (start-to-request latency 1 cycle).
REQ-022 SHALL transition S_RD_FETCH -> S_RD_FINISH on the cycle issued reaches size.
REQ-023 SHALL accept a response only if rd_rsp_valid=1, state!=S_RD_IDLE and rd_rsp_mdata[15]==epoch; mismatched-epoch or IDLE responses SHALL be dropped without side effects.
REQ-024 SHALL push accepted {data, mdata[14:0]} into the FIFO and decrement outstanding; responses may arrive in any order, out_idx carries the line index unmodified.
REQ-025 SHALL keep outstanding unchanged when an issue and an accepted response occur in the same cycle.
REQ-026 SHALL never overflow the FIFO (guaranteed by REQ-019 credit rule); out_valid = FIFO non-empty, pop on out_valid && out_ready; push and pop in the same cycle SHALL both occur.
REQ-027 SHALL transition S_RD_FINISH -> S_RD_IDLE when outstanding==0 and FIFO empty, pulsing done=1 in that transition cycle.
REQ-028 SHALL use 32-bit issued/outstanding counters; out_idx wraps modulo 32768 for size > 32768.

Reset
REQ-029 SHALL on reset force state S_RD_IDLE, rd_req_valid=0, out_valid=0, busy=0, done=0, FIFO empty, counters 0, epoch 0.
REQ-030 SHALL, on reset mid-operation, abandon the job; later responses are dropped while IDLE.

Verification
REQ-031 size=4, base=0x1000, in-order responses, out_ready=1 -> requests 0x1000..0x1003 mdata 0x8000..0x8003, out_idx 0..3, one done pulse, busy low after.
REQ-032 size=4, responses returned order 3,1,0,2 -> out_idx sequence 3,1,0,2, data matches per index, done after 4th pop.
REQ-033 size=100, out_ready=0, immediate responses -> exactly 64 requests issued then stall; release out_ready -> remaining 36 issued, 100 outputs, done.
REQ-034 c0TxAlmFull=1 for 10 cycles after start -> no rd_req_valid during those cycles, issue resumes the cycle after deassert.
REQ-035 size=0 -> no requests, done pulses 2 cycles after start; start during busy on another job -> ignored.
REQ-036 reset after 5 of 10 requests, then stale responses with old epoch, then new start size=2 -> stale dropped, only out_idx 0,1 emitted.

Source files
------------

// File: rtl/sobel_rd_engine.sv
// sobel_rd_engine: issues cache-line read requests for one buffer and hands the
// responses to the sobel core as a first-word-fall-through stream.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   start                 one-cycle job start pulse (ignored while busy)
//   base_addr, size       buffer base (cache-line address) and length in lines
//   c0TxAlmFull           read request channel almost-full, stalls issue
//   rd_req_valid/addr/mdata  registered read request, mdata = {epoch, line_index}
//   rd_rsp_valid/mdata/data  read responses, any order
//   out_valid/ready/data/idx stream of returned lines with their line index
//   busy, done            job in progress / one-cycle completion pulse
//
// FIFO_DEPTH must be a power of two and at least 2.
module sobel_rd_engine #(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [41:0]  base_addr,
  input  logic [31:0]  size,
  input  logic         c0TxAlmFull,
  output logic         rd_req_valid,
  output logic [41:0]  rd_req_addr,
  output logic [15:0]  rd_req_mdata,
  input  logic         rd_rsp_valid,
  input  logic [15:0]  rd_rsp_mdata,
  input  logic [511:0] rd_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic [14:0]  out_idx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_RD_IDLE, S_RD_FETCH, S_RD_FINISH} state_e;

  state_e      state_q;
  logic [41:0] base_q;
  logic [31:0] size_q;
  logic [31:0] issued_q;
  logic [31:0] outstanding_q;
  logic        epoch_q;
  logic        req_valid_q;
  logic [41:0] req_addr_q;
  logic [15:0] req_mdata_q;
  logic        done_q;

  logic [526:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic credit_ok, fetch_issue, start_issue, rsp_accept, push, pop;

  always_comb begin
    // Outstanding requests plus buffered lines bound how much can ever land in the FIFO.
    credit_ok   = ({1'b0, outstanding_q} + 33'(count_q)) < 33'(FIFO_DEPTH);
    fetch_issue = (state_q == S_RD_FETCH) && (issued_q < size_q) && !c0TxAlmFull && credit_ok;
    // The first request leaves on the start edge itself; the FIFO is empty in idle.
    start_issue = (state_q == S_RD_IDLE) && start && (size != 32'd0) && !c0TxAlmFull;
    rsp_accept  = rd_rsp_valid && (state_q != S_RD_IDLE) && (rd_rsp_mdata[15] == epoch_q);
    push        = rsp_accept;
    pop         = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RD_IDLE;
      base_q        <= '0;
      size_q        <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      epoch_q       <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_mdata_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        S_RD_IDLE: begin
          if (start) begin
            base_q        <= base_addr;
            size_q        <= size;
            epoch_q       <= ~epoch_q;
            issued_q      <= {31'd0, start_issue};
            outstanding_q <= {31'd0, start_issue};
            if (start_issue) begin
              req_valid_q <= 1'b1;
              req_addr_q  <= base_addr;
              req_mdata_q <= {~epoch_q, 15'd0};
            end
            state_q <= (size == 32'd0) ? S_RD_FINISH : S_RD_FETCH;
          end
        end
        S_RD_FETCH: begin
          if (fetch_issue) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= base_q + {10'd0, issued_q};
            req_mdata_q <= {epoch_q, issued_q[14:0]};
            issued_q    <= issued_q + 32'd1;
          end
          if (issued_q == size_q) state_q <= S_RD_FINISH;
        end
        S_RD_FINISH: begin
          if ((outstanding_q == 32'd0) && (count_q == '0)) begin
            state_q <= S_RD_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_RD_IDLE;
      endcase
      if (state_q != S_RD_IDLE) begin
        if (fetch_issue && !rsp_accept) outstanding_q <= outstanding_q + 32'd1;
        else if (!fetch_issue && rsp_accept) outstanding_q <= outstanding_q - 32'd1;
      end
    end
  end

  // Response FIFO: pointers/count reset, storage does not need to.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {rd_rsp_data, rd_rsp_mdata[14:0]};
  end

  assign out_valid           = (count_q != '0);
  assign {out_data, out_idx} = mem[rptr_q];

  assign rd_req_valid = req_valid_q;
  assign rd_req_addr  = req_addr_q;
  assign rd_req_mdata = req_mdata_q;
  assign busy         = (state_q != S_RD_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_sobel_rd_engine.sv
// Directed bench for sobel_rd_engine. Inputs change 1 ns after the rising edge,
// outputs are sampled there too; a pop is logged just before the edge that performs it.
module tb_sobel_rd_engine;

  logic         clk = 1'b0;
  logic         reset, start, c0TxAlmFull;
  logic [41:0]  base_addr;
  logic [31:0]  size;
  logic         rd_req_valid;
  logic [41:0]  rd_req_addr;
  logic [15:0]  rd_req_mdata;
  logic         rd_rsp_valid;
  logic [15:0]  rd_rsp_mdata;
  logic [511:0] rd_rsp_data;
  logic         out_valid, out_ready;
  logic [511:0] out_data;
  logic [14:0]  out_idx;
  logic         busy, done;

  int total = 0;
  int bad   = 0;
  int done_cnt;
  logic ep;

  logic [41:0]  req_addr_q[$];
  logic [15:0]  req_md_q[$];
  logic [14:0]  pop_idx_q[$];
  logic [511:0] pop_dat_q[$];

  always #5 clk = ~clk;

  sobel_rd_engine #(.FIFO_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .size(size),
    .c0TxAlmFull(c0TxAlmFull), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_mdata(rd_req_mdata), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
  );

  function automatic logic [511:0] dat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ i;
    return {16{w}};
  endfunction

  task automatic tick();
    if (out_valid && out_ready) begin
      pop_idx_q.push_back(out_idx);
      pop_dat_q.push_back(out_data);
    end
    @(posedge clk); #1;
    if (rd_req_valid) begin
      req_addr_q.push_back(rd_req_addr);
      req_md_q.push_back(rd_req_mdata);
    end
    if (done) done_cnt++;
  endtask

  task automatic clear();
    req_addr_q.delete(); req_md_q.delete(); pop_idx_q.delete(); pop_dat_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [41:0] b, input logic [31:0] s);
    base_addr = b; size = s; start = 1'b1; ep = ~ep;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rsp(input int idx, input logic e);
    rd_rsp_valid = 1'b1; rd_rsp_mdata = {e, 15'(idx)}; rd_rsp_data = dat(idx);
    tick();
    rd_rsp_valid = 1'b0;
  endtask

  // Answers whatever request was just issued on the next edge.
  task automatic tick_echo();
    if (rd_req_valid) begin
      rd_rsp_valid = 1'b1; rd_rsp_mdata = rd_req_mdata; rd_rsp_data = dat(int'(rd_req_mdata[14:0]));
    end else rd_rsp_valid = 1'b0;
    tick();
  endtask

  task automatic wait_reqs(input int n, input int limit, input string name);
    int k = 0;
    while (req_addr_q.size() < n && k < limit) begin tick(); k++; end
    total++;
    if (req_addr_q.size() !== n) begin
      bad++; $display("FAIL %s req count got %0d want %0d", name, req_addr_q.size(), n);
    end
  endtask

  task automatic wait_done(input int limit, input string name);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin tick(); k++; end
    tick(); tick();
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL %s done pulses got %0d want 1", name, done_cnt); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy after done got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); tick();
    total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL reset rd_req_valid got %b want 0", rd_req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got %b want 0", done); end
    reset = 1'b0; ep = 1'b0; tick();
  endtask

  task automatic test_in_order();
    clear(); out_ready = 1'b1;
    start_job(42'h1000, 32'd4);
    total++;
    if (rd_req_valid !== 1'b1 || rd_req_addr !== 42'h1000) begin
      bad++; $display("FAIL start latency valid=%b addr=%h want 1/1000", rd_req_valid, rd_req_addr);
    end
    wait_reqs(4, 20, "in_order");
    for (int i = 0; i < 4 && i < req_addr_q.size(); i++) begin
      total++;
      if (req_addr_q[i] !== 42'h1000 + 42'(i) || req_md_q[i] !== 16'h8000 + 16'(i)) begin
        bad++; $display("FAIL in_order req%0d addr=%h md=%h want %h/%h", i, req_addr_q[i],
                        req_md_q[i], 42'h1000 + 42'(i), 16'h8000 + 16'(i));
      end
    end
    for (int i = 0; i < 4; i++) send_rsp(i, ep);
    wait_done(30, "in_order");
    total++;
    if (pop_idx_q.size() !== 4) begin bad++; $display("FAIL in_order pops got %0d want 4", pop_idx_q.size()); end
    for (int i = 0; i < 4 && i < pop_idx_q.size(); i++) begin
      total++;
      if (pop_idx_q[i] !== 15'(i) || pop_dat_q[i] !== dat(i)) begin
        bad++; $display("FAIL in_order out%0d idx=%0d want %0d (data ok=%b)", i, pop_idx_q[i], i,
                        pop_dat_q[i] === dat(i));
      end
    end
  endtask

  task automatic test_out_of_order();
    int order [4] = '{3, 1, 0, 2};
    clear(); out_ready = 1'b1;
    start_job(42'h2000, 32'd4);
    wait_reqs(4, 20, "ooo");
    for (int i = 0; i < 4; i++) send_rsp(order[i], ep);
    total++;
    if (done_cnt !== 0) begin bad++; $display("FAIL ooo early done got %0d want 0", done_cnt); end
    wait_done(30, "ooo");
    total++;
    if (pop_idx_q.size() !== 4) begin bad++; $display("FAIL ooo pops got %0d want 4", pop_idx_q.size()); end
    for (int i = 0; i < 4 && i < pop_idx_q.size(); i++) begin
      total++;
      if (pop_idx_q[i] !== 15'(order[i]) || pop_dat_q[i] !== dat(order[i])) begin
        bad++; $display("FAIL ooo out%0d idx=%0d want %0d (data ok=%b)", i, pop_idx_q[i], order[i],
                        pop_dat_q[i] === dat(order[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    clear(); out_ready = 1'b0;
    start_job(42'h4000, 32'd100);
    for (int i = 0; i < 200; i++) tick_echo();
    total++;
    if (req_addr_q.size() !== 64) begin
      bad++; $display("FAIL credit stall reqs got %0d want 64", req_addr_q.size());
    end
    total++;
    if (pop_idx_q.size() !== 0) begin bad++; $display("FAIL credit stall pops got %0d want 0", pop_idx_q.size()); end
    out_ready = 1'b1;
    while (done_cnt == 0 && k < 1500) begin tick_echo(); k++; end
    rd_rsp_valid = 1'b0;
    tick(); tick();
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL bp done pulses got %0d want 1", done_cnt); end
    total++;
    if (req_addr_q.size() !== 100) begin bad++; $display("FAIL bp reqs got %0d want 100", req_addr_q.size()); end
    total++;
    if (pop_idx_q.size() !== 100) begin bad++; $display("FAIL bp pops got %0d want 100", pop_idx_q.size()); end
    for (int i = 0; i < 100 && i < pop_idx_q.size(); i++) begin
      total++;
      if (pop_idx_q[i] !== 15'(i) || pop_dat_q[i] !== dat(i)) begin
        bad++; $display("FAIL bp out%0d idx=%0d want %0d", i, pop_idx_q[i], i);
      end
    end
  endtask

  task automatic test_almfull();
    clear(); out_ready = 1'b1; c0TxAlmFull = 1'b1;
    start_job(42'h6000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    total++;
    if (req_addr_q.size() !== 0) begin bad++; $display("FAIL almfull reqs got %0d want 0", req_addr_q.size()); end
    c0TxAlmFull = 1'b0;
    tick();
    total++;
    if (rd_req_valid !== 1'b1 || rd_req_addr !== 42'h6000 || rd_req_mdata !== {ep, 15'd0}) begin
      bad++; $display("FAIL almfull resume valid=%b addr=%h md=%h want 1/6000/%h", rd_req_valid,
                      rd_req_addr, rd_req_mdata, {ep, 15'd0});
    end
    wait_reqs(3, 20, "almfull");
    for (int i = 0; i < 3; i++) send_rsp(i, ep);
    wait_done(30, "almfull");
  endtask

  task automatic test_size_zero_and_busy_start();
    clear(); out_ready = 1'b1;
    start_job(42'h5000, 32'd0);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero c1 busy=%b done=%b want 1/0", busy, done); end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero c2 done=%b busy=%b want 1/0", done, busy); end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL zero pulse width done=%b want 0", done); end
    total++;
    if (req_addr_q.size() !== 0) begin bad++; $display("FAIL zero reqs got %0d want 0", req_addr_q.size()); end
    clear();
    start_job(42'h7000, 32'd2);
    tick();
    base_addr = 42'h9000; size = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    send_rsp(0, ep); send_rsp(1, ep);
    wait_done(30, "busy_start");
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (req_addr_q.size() !== 2) begin bad++; $display("FAIL busy_start reqs got %0d want 2", req_addr_q.size()); end
    else begin
      total++;
      if (req_addr_q[1] !== 42'h7001 || req_md_q[1] !== {ep, 15'd1}) begin
        bad++; $display("FAIL busy_start req1 addr=%h md=%h want 7001/%h", req_addr_q[1], req_md_q[1], {ep, 15'd1});
      end
    end
  endtask

  task automatic test_reset_mid_job();
    logic old_ep;
    clear(); out_ready = 1'b1;
    start_job(42'hA000, 32'd10);
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (req_addr_q.size() !== 5) begin bad++; $display("FAIL midreset reqs got %0d want 5", req_addr_q.size()); end
    reset = 1'b1; tick(); reset = 1'b0;
    old_ep = ep; ep = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset busy got %b want 0", busy); end
    for (int i = 0; i < 5; i++) send_rsp(i, old_ep);
    tick();
    total++;
    if (out_valid !== 1'b0 || pop_idx_q.size() !== 0) begin
      bad++; $display("FAIL stale accepted out_valid=%b pops=%0d want 0/0", out_valid, pop_idx_q.size());
    end
    clear();
    start_job(42'hB000, 32'd2);
    wait_reqs(2, 20, "restart");
    send_rsp(1, ~ep);
    send_rsp(0, ep); send_rsp(1, ep);
    wait_done(30, "restart");
    total++;
    if (pop_idx_q.size() !== 2) begin bad++; $display("FAIL restart pops got %0d want 2", pop_idx_q.size()); end
    else begin
      total++;
      if (pop_idx_q[0] !== 15'd0 || pop_idx_q[1] !== 15'd1 || pop_dat_q[1] !== dat(1)) begin
        bad++; $display("FAIL restart idx got %0d,%0d want 0,1", pop_idx_q[0], pop_idx_q[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; c0TxAlmFull = 1'b0; base_addr = '0; size = '0;
    rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0; out_ready = 1'b0;
    ep = 1'b0; done_cnt = 0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_backpressure();
    test_almfull();
    test_size_zero_and_busy_start();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
